// File: rtl/regfile_fwd_if.sv
// Register-file bus: write-back port, two ID read ports and the EX/MEM
// forwarding taps. The pipeline side is the master, the register file the slave.
interface regfile_fwd_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // MEM/WB write-back
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    // ID source-operand reads
    logic            re1;
    logic [AW-1:0]   raddr1;
    logic [XLEN-1:0] rdata1;
    logic            re2;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata2;

    // EX stage forwarding tap
    logic            ex_wreg;
    logic [AW-1:0]   ex_wd;
    logic [XLEN-1:0] ex_wdata;
    logic            ex_is_load;

    // MEM stage forwarding tap
    logic            mem_wreg;
    logic [AW-1:0]   mem_wd;
    logic [XLEN-1:0] mem_wdata;

    // load-use hazard
    logic            stallreq;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        output ex_wreg, ex_wd, ex_wdata, ex_is_load,
        output mem_wreg, mem_wd, mem_wdata,
        input  rdata1, rdata2, stallreq
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        input  ex_wreg, ex_wd, ex_wdata, ex_is_load,
        input  mem_wreg, mem_wd, mem_wdata,
        output rdata1, rdata2, stallreq
    );
endinterface

// File: rtl/regfile_fwd.sv
// RV32I integer register file with EX/MEM/WB operand forwarding and
// load-use stall detection. x0 is not stored and always reads zero.
module regfile_fwd #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input logic         clk,
    input logic         rst,
    regfile_fwd_if.slave bus
);

    // x1..x(NREG-1) only; x0 has no storage
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];

    // Per-port request, gathered so both ports share one generate body
    logic [1:0]      ren_w;
    logic [AW-1:0]   raddr_w [2];

    assign ren_w[0]   = bus.re1;
    assign ren_w[1]   = bus.re2;
    assign raddr_w[0] = bus.raddr1;
    assign raddr_w[1] = bus.raddr2;

    // Next array state: reset clears everything and drops any concurrent write
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = rst ? '0 : regs_q[i];
        end
        if (!rst && bus.we && (bus.waddr != '0)) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    // Commit the array on every rising edge
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [XLEN-1:0] rd;
            logic            ex_hit;

            // EX match on a live, non-zero source; feeds the load-use check
            assign ex_hit = ren_w[gi] && (raddr_w[gi] != '0) &&
                            bus.ex_wreg && (bus.ex_wd == raddr_w[gi]);

            // Newest value wins: EX, then MEM, then write-through, then array
            always_comb begin
                rd = '0;
                if (rst || !ren_w[gi] || (raddr_w[gi] == '0)) begin
                    rd = '0;
                end else if (bus.ex_wreg && (bus.ex_wd == raddr_w[gi])) begin
                    rd = bus.ex_wdata;
                end else if (bus.mem_wreg && (bus.mem_wd == raddr_w[gi])) begin
                    rd = bus.mem_wdata;
                end else if (bus.we && (bus.waddr == raddr_w[gi])) begin
                    rd = bus.wdata;
                end else begin
                    rd = regs_q[raddr_w[gi]];
                end
            end
        end
    endgenerate

    assign bus.rdata1 = g_port[0].rd;
    assign bus.rdata2 = g_port[1].rd;

    // A load in EX cannot forward yet, so any consumer of its result must wait.
    // ex_hit already excludes x0 because a zero source address never matches.
    assign bus.stallreq = !rst && bus.ex_is_load &&
                          (g_port[0].ex_hit || g_port[1].ex_hit);

endmodule

// File: doc/regfile_fwd.md
# regfile_fwd

Integer register file for the RV32I pipeline, with operand forwarding built in. It is the write-back end of the execute-stage result interface (destination address, write enable, write data): it holds x0..x31 and commits results retired from MEM/WB. It serves the ID stage's two source-operand reads. In-flight EX and MEM results are forwarded so ID always sees the newest architectural value. A load-use stall request is raised when forwarding cannot help.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of registers; x0 is hardwired zero
- AW, 5, register address width (log2 NREG)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write-back enable (from MEM/WB)
- waddr  in  AW  write-back destination register
- wdata  in  XLEN  write-back data
- re1 / re2  in  1  read enables, source operands 1 and 2
- raddr1 / raddr2  in  AW  source register addresses
- rdata1 / rdata2  out  XLEN  operand values (combinational)
- ex_wreg  in  1  EX stage will write a register
- ex_wd  in  AW  EX destination register
- ex_wdata  in  XLEN  EX result
- ex_is_load  in  1  EX instruction is a load (data not yet available)
- mem_wreg  in  1  MEM stage will write a register
- mem_wd  in  AW  MEM destination register
- mem_wdata  in  XLEN  MEM result (load data already resolved)
- stallreq  out  1  load-use hazard; ID/IF must hold

## Operation
- Storage: NREG-1 registers of XLEN bits (x1..x31); x0 is not stored and always reads 0.
- Write: on a rising edge with rst=0, we=1 and waddr!=0, reg[waddr] <= wdata. Writes to x0 are dropped silently.
- Reset: on a rising edge with rst=1, all registers clear to 0 and any concurrent write is discarded. While rst=1, rdata1/rdata2 = 0 and stallreq = 0.
- Read, per port n, with rst=0. First match wins:
  1. ren=0 -> 0
  2. raddrn=0 -> 0
  3. ex_wreg=1 and ex_wd=raddrn -> ex_wdata
  4. mem_wreg=1 and mem_wd=raddrn -> mem_wdata
  5. we=1 and waddr=raddrn -> wdata (write-through bypass)
  6. otherwise -> reg[raddrn]
- A forwarding source whose destination is x0 never matches, because rule 2 takes precedence.
- stallreq = ex_wreg and ex_is_load and ex_wd!=0 and ((re1 and raddr1=ex_wd) or (re2 and raddr2=ex_wd)).
- While stallreq=1, rdata still follows rule 3. The value is stale and the ID stage must ignore it.
- Both ports are independent. Reading the same address on both ports returns identical values.

## Timing
- Read path is fully combinational from addresses, enables and forward inputs to rdata and stallreq. There is zero-cycle read latency.
- Write latency is 1 cycle: data is visible from the array on the edge after we. Rule 5 makes it visible in the same cycle.
- Reset takes effect on the first rising edge with rst=1; registers read 0 from the next cycle.
- rst can be deasserted in any cycle. The first write accepted is in the first cycle with rst=0.
- Reset mid-operation: any pending we in the rst cycle is lost. No partial register state survives.
- Simultaneous EX, MEM and WB writes to the same register: EX has priority for reads. The array commits only the WB value on that edge.
- Register outputs have no reset value of their own because the read path is combinational. With rst=1 they are forced to 0.

## Test plan
- Reset: write x5=0xDEADBEEF, then assert rst for 1 cycle -> raddr1=5 reads 0x00000000. stallreq=0 throughout.
- Write/read and x0: we=1 waddr=0 wdata=0x1234 -> x0 reads 0. we=1 waddr=31 wdata=0xA5A5A5A5 -> next cycle raddr2=31 reads 0xA5A5A5A5.
- Write-through: in the same cycle set we=1, waddr=7, wdata=0x11, raddr1=7 -> rdata1=0x11 in that cycle and thereafter.
- Forward priority: x3=0x1, WB x3=0x2, MEM x3=0x3, EX x3=0x4 -> rdata1=0x4. Drop ex_wreg -> 0x3. Drop mem_wreg -> 0x2.
- Load-use: ex_wreg=1, ex_is_load=1, ex_wd=9, raddr2=9, re2=1 -> stallreq=1. Set re2=0 -> stallreq=0. Set ex_wd=0 -> stallreq=0.
- Read enable: re1=0, raddr1=31 holding 0xA5A5A5A5 -> rdata1=0. Both ports at raddr=31 -> both return 0xA5A5A5A5.
